// File: rtl/prio_arbiter_fsm.sv
// Fixed-priority 4-way arbiter (req[3] highest): holds the grant until done, owner withdraw or MAX_HOLD cycles.
// Latency: grant one cycle after request, one-cycle bubble between grants; no backpressure, all outputs registered.
module prio_arbiter_fsm #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_gnt_id, w_gnt_id_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic       w_win_vld;
  logic [1:0] w_win_id;
  logic       w_owner_req;
  logic       w_expire;

  always_comb begin
    w_win_vld = |req;
    w_win_id  = 2'd0;
    casez (req)
      4'b1???: w_win_id = 2'd3;
      4'b01??: w_win_id = 2'd2;
      4'b001?: w_win_id = 2'd1;
      default: w_win_id = 2'd0;
    endcase
  end

  assign w_owner_req = req[r_gnt_id];
  assign w_expire    = (r_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_gnt     <= 4'd0;
      r_gnt_id  <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_RELEASE: begin
        w_cnt_nxt  = 8'd0;
        w_gnt_nxt  = 4'd0;
        w_busy_nxt = 1'b0;
        if (w_win_vld) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = 4'b0001 << w_win_id;
          w_gnt_id_nxt = w_win_id;
          w_busy_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (done || !w_owner_req || w_expire) begin
          w_state_nxt   = S_RELEASE;
          w_cnt_nxt     = 8'd0;
          w_gnt_nxt     = 4'd0;
          w_busy_nxt    = 1'b0;
          // Pulse only when the hold limit alone ended the grant.
          w_timeout_nxt = w_expire && !done && w_owner_req;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
        w_gnt_nxt   = 4'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_prio_arbiter_fsm.sv
// Bench for prio_arbiter_fsm: directed vector table, async-reset sequence, then random traffic vs a reference model.
module tb_prio_arbiter_fsm;

  localparam int MAX_HOLD = 4;
  localparam int NVEC = 22;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none) and how many cycles it has held the grant.
  int         m_owner;
  int         m_age;
  logic [1:0] m_last_id;
  logic       m_tmo;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  prio_arbiter_fsm #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner   = -1;
    m_age     = 0;
    m_last_id = 2'd0;
    m_tmo     = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_age == MAX_HOLD) begin
        m_tmo   = !d && r[m_owner];
        m_owner = -1;
      end else begin
        m_age++;
        m_tmo = 1'b0;
      end
    end else begin
      m_tmo = 1'b0;
      for (int b = 3; b >= 0; b--)
        if (r[b] && m_owner < 0) m_owner = b;
      if (m_owner >= 0) begin
        m_age     = 1;
        m_last_id = 2'(m_owner);
      end
    end
  endfunction

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [3:0] r, input logic d,
                         input logic [3:0] g, input logic [1:0] id, input logic b, input logic t);
    vecs[i].req  = r;
    vecs[i].done = d;
    vecs[i].gnt  = g;
    vecs[i].id   = id;
    vecs[i].busy = b;
    vecs[i].tmo  = t;
  endtask

  initial begin
    logic [3:0] rr;
    logic [3:0] eg;

    set_vec( 0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    set_vec( 1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    set_vec( 2, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    set_vec( 3, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    set_vec( 4, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    set_vec( 5, 4'b0011, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    set_vec( 6, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    set_vec( 7, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
    set_vec( 8, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
    set_vec( 9, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(10, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(11, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(12, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(13, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    set_vec(14, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(15, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(16, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(17, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    set_vec(18, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    set_vec(19, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    set_vec(20, 4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    set_vec(21, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);

    rst_n = 1'b0;
    req   = 4'd0;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 8'(gnt), 8'h0);
    chk("reset gnt_id", 8'(gnt_id), 8'h0);
    chk("reset busy", 8'(busy), 8'h0);
    chk("reset timeout", 8'(timeout), 8'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d gnt", i), 8'(gnt), 8'(vecs[i].gnt));
      chk($sformatf("vec%0d gnt_id", i), 8'(gnt_id), 8'(vecs[i].id));
      chk($sformatf("vec%0d busy", i), 8'(busy), 8'(vecs[i].busy));
      chk($sformatf("vec%0d timeout", i), 8'(timeout), 8'(vecs[i].tmo));
    end

    // Asynchronous reset while requester 2 holds the grant.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("pre-reset gnt", 8'(gnt), 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset gnt", 8'(gnt), 8'h0);
    chk("async reset busy", 8'(busy), 8'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      chk($sformatf("post-reset idle%0d gnt", i), 8'(gnt), 8'h0);
      chk($sformatf("post-reset idle%0d gnt_id", i), 8'(gnt_id), 8'h0);
      chk($sformatf("post-reset idle%0d busy", i), 8'(busy), 8'h0);
      chk($sformatf("post-reset idle%0d timeout", i), 8'(timeout), 8'h0);
    end

    rr = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      step(rr, $urandom_range(0, 9) == 0);
      eg = 4'd0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("rand gnt", 8'(gnt), 8'(eg));
      chk("rand gnt_id", 8'(gnt_id), 8'(m_last_id));
      chk("rand busy", 8'(busy), 8'(m_owner >= 0));
      chk("rand timeout", 8'(timeout), 8'(m_tmo));
      chk("rand onehot", 8'($countones(gnt) <= 1), 8'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
